// File: rtl/vm_pkg.sv
// Shared types and constants for the vending machine controller.
package vm_pkg;

    localparam int PRICE = 15;
    localparam int COIN_UNIT = 5;

    // Credit held between cycles; encoding order matches credit / COIN_UNIT.
    typedef enum logic [1:0] {
        S0  = 2'd0,
        S5  = 2'd1,
        S10 = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        C5     = 2'b01,
        C10    = 2'b10,
        CANCEL = 2'b11
    } coin_t;

    typedef enum logic [1:0] {
        CHG_NONE = 2'b00,
        CHG_5    = 2'b01,
        CHG_10   = 2'b10
    } chg_t;

endpackage

// File: rtl/vm_sales_cnt.sv
// Wrapping dispense counter, instantiated by vm only when VM_SALES_CNT_EN is defined.
module vm_sales_cnt #(
    parameter int SALES_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inc_i,
    output logic [SALES_CNT_W-1:0] cnt_o
);

    logic [SALES_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + SALES_CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vm.sv
// Vending machine FSM: 15-unit item, 5/10-unit coins, cancel refunds held credit.
// Optional dispense counter enabled by defining VM_SALES_CNT_EN.
//
// state | meaning
// S0    | no credit held
// S5    | 5 units held
// S10   | 10 units held
module vm
    import vm_pkg::*;
#(
    parameter int SALES_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             in,
    output logic                   out,
    output logic [1:0]             change
`ifdef VM_SALES_CNT_EN
    ,
    output logic [SALES_CNT_W-1:0] sales_cnt
`endif
);

    state_t state_q, state_d;
    logic   out_q, out_d;
    chg_t   change_q, change_d;
    coin_t  coin;

    assign coin = coin_t'(in);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S0;
            out_q    <= 1'b0;
            change_q <= CHG_NONE;
        end else begin
            state_q  <= state_d;
            out_q    <= out_d;
            change_q <= change_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        out_d    = 1'b0;
        change_d = CHG_NONE;
        case (state_q)
            S0: begin
                case (coin)
                    C5:      state_d = S5;
                    C10:     state_d = S10;
                    default: state_d = S0;
                endcase
            end
            S5: begin
                case (coin)
                    C5:  state_d = S10;
                    C10: begin
                        state_d = S0;
                        out_d   = 1'b1;
                    end
                    CANCEL: begin
                        state_d  = S0;
                        change_d = CHG_5;
                    end
                    default: state_d = S5;
                endcase
            end
            S10: begin
                case (coin)
                    C5: begin
                        state_d = S0;
                        out_d   = 1'b1;
                    end
                    // 20 units in: dispense and return the surplus 5
                    C10: begin
                        state_d  = S0;
                        out_d    = 1'b1;
                        change_d = CHG_5;
                    end
                    CANCEL: begin
                        state_d  = S0;
                        change_d = CHG_10;
                    end
                    default: state_d = S10;
                endcase
            end
            default: state_d = S0;
        endcase
    end

    assign out    = out_q;
    assign change = change_q;

`ifdef VM_SALES_CNT_EN
    // Counts on the same edge that registers the dispense pulse.
    vm_sales_cnt #(
        .SALES_CNT_W(SALES_CNT_W)
    ) u_sales_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (out_d),
        .cnt_o (sales_cnt)
    );
`endif

endmodule

// File: tb/tb_vm.sv
// Randomized self-checking bench for vm against a credit-in-units reference model.
module tb_vm;

    localparam int W = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [1:0]   in_s = 2'b00;
    logic         out_s;
    logic [1:0]   change_s;
`ifdef VM_SALES_CNT_EN
    logic [W-1:0] sales_cnt_s;
`endif

    int n_chk = 0;
    int n_pass = 0;

    int credit = 0;
    int exp_out = 0;
    int exp_chg = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    vm #(.SALES_CNT_W(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .in     (in_s),
        .out    (out_s),
        .change (change_s)
`ifdef VM_SALES_CNT_EN
        ,
        .sales_cnt (sales_cnt_s)
`endif
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp)
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        else
            n_pass++;
    endtask

    // Model: credit in units; reaching the price dispenses and refunds any surplus.
    task automatic model(input logic [1:0] v, input bit rst);
        exp_out = 0;
        exp_chg = 0;
        if (rst) begin
            credit  = 0;
            exp_cnt = 0;
        end else if (v == 2'b11) begin
            exp_chg = credit / 5;
            credit  = 0;
        end else if (v != 2'b00) begin
            credit = credit + ((v == 2'b01) ? 5 : 10);
            if (credit >= 15) begin
                exp_out = 1;
                exp_chg = (credit - 15) / 5;
                credit  = 0;
                exp_cnt = (exp_cnt + 1) % (1 << W);
            end
        end
    endtask

    task automatic step(input logic [1:0] v, input bit rst, input string tag);
        @(negedge clk);
        in_s  = v;
        reset = rst;
        @(posedge clk);
        model(v, rst);
        #1;
        chk({tag, ".out"}, int'(out_s), exp_out);
        chk({tag, ".chg"}, int'(change_s), exp_chg);
        chk({tag, ".state"}, int'(dut.state_q), credit / 5);
`ifdef VM_SALES_CNT_EN
        chk({tag, ".cnt"}, int'(sales_cnt_s), exp_cnt);
`endif
    endtask

    initial begin
        step(2'b01, 1'b1, "rst0");
        step(2'b10, 1'b1, "rst1");
        // consecutive coins including the 10+10 case
        step(2'b01, 1'b0, "seq_a");
        step(2'b01, 1'b0, "seq_b");
        step(2'b10, 1'b0, "seq_c");
        step(2'b10, 1'b0, "seq_d");
        step(2'b11, 1'b0, "seq_cancel10");
        // 10 then 5
        step(2'b10, 1'b0, "t25a");
        step(2'b01, 1'b0, "t25b");
        step(2'b00, 1'b0, "t25c");
        // cancels
        step(2'b01, 1'b0, "c5a");
        step(2'b11, 1'b0, "c5b");
        step(2'b10, 1'b0, "c10a");
        step(2'b11, 1'b0, "c10b");
        step(2'b11, 1'b0, "c0");
        // credit held across idle cycles
        step(2'b01, 1'b0, "idle_a");
        for (int i = 0; i < 5; i++) step(2'b00, 1'b0, "idle");
        step(2'b10, 1'b0, "idle_b");
        // reset discards credit without refund
        step(2'b10, 1'b0, "rc_a");
        step(2'b11, 1'b1, "rc_rst");
        step(2'b01, 1'b0, "rc_b");
        step(2'b00, 1'b1, "rc_clr");
        // five purchases exercise counter wrap
        for (int i = 0; i < 5; i++) begin
            step(2'b10, 1'b0, "buy_a");
            step(2'b01, 1'b0, "buy_b");
        end
        for (int i = 0; i < 400; i++)
            step(2'($urandom_range(0, 3)), ($urandom_range(0, 39) == 0), "rnd");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
